softmax_row_engine: RTL and testbench

- Self-buffering, parametrised softmax for one attention row of up to LANES*MAX_BEATS scores.
- The row is streamed in once. The block tracks the running maximum, computes max-subtracted base-2 exponents, takes one reciprocal per row, and replays the normalised row out with a valid/ready handshake.
- The producer no longer sends the row twice, and the block does not depend on an external sum_clear.
- It sits between the QK score path and the score*V multiplier.

---
 rtl/softmax_row_engine.sv | 204 ++++++++++++++++++++
 tb/tb_softmax_row_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_engine.sv
// Single-row softmax: buffer the row once, exp2(score-max), one reciprocal, replay normalised beats (latency 2B+32).
// in_rdy only in LOAD; out beats advance on out_vld&out_rdy. SOFTMAX_LANE_MASK_EN adds per-lane in_mask.
module softmax_row_engine #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int MAX_BEATS  = 16,
  parameter int INFO_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  input  logic [INFO_WIDTH-1:0]       in_info,
`ifdef SOFTMAX_LANE_MASK_EN
  input  logic [LANES-1:0]            in_mask,
`endif
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [LANES*16-1:0]         out_data,
  output logic                        out_last,
  output logic [INFO_WIDTH-1:0]       out_info,
  output logic                        busy,
  output logic                        err_len
);

  localparam int EW  = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
  localparam int IW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int PW  = $clog2(MAX_BEATS + 1);
  localparam int SW  = 16 + $clog2(LANES * MAX_BEATS);
  localparam int DW1 = DATA_WIDTH + 1;
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_DIV, S_OUT} state_t;
  state_t state_q, state_d;

  logic [EW-1:0]                 mem [MAX_BEATS][LANES];
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic signed [DATA_WIDTH-1:0]  max_q, beat_max;
  logic [SW-1:0]                 sum_q, e_sum, rem_q;
  logic [15:0]                   q_q, recip;
  logic [4:0]                    div_cnt;
  logic [INFO_WIDTH-1:0]         info_q;
  logic [LANES-1:0]              in_act, rd_act;
  logic                          accept, last_beat, exp_done, div_done, out_fire, ge;
  logic [SW:0]                   rem_sh;
  logic [IW-1:0]                 wr_idx, rd_idx;
  logic signed [DW1-1:0]         d_l  [LANES];
  logic signed [DW1-1:0]         sh_l [LANES];
  logic [15:0]                   e_lane [LANES];
  logic [LANES*16-1:0]           out_lanes;

  assign wr_idx    = wr_ptr[IW-1:0];
  assign rd_idx    = rd_ptr[IW-1:0];
  assign accept    = in_vld && (state_q == S_LOAD);
  assign last_beat = in_last || (wr_ptr == PW'(MAX_BEATS - 1));
  assign exp_done  = (rd_ptr == wr_ptr - PW'(1));
  assign div_done  = (div_cnt == 5'd30);
  assign out_fire  = out_vld && out_rdy;
  assign out_info  = info_q;

`ifdef SOFTMAX_LANE_MASK_EN
  logic [LANES-1:0] mask_mem [MAX_BEATS];
  assign in_act = ~in_mask;
  assign rd_act = ~mask_mem[rd_idx];
  always_ff @(posedge clk) begin
    if (accept) mask_mem[wr_idx] <= in_mask;
  end
`else
  assign in_act = '1;
  assign rd_act = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    busy    = 1'b1;
    case (state_q)
      S_LOAD: begin
        in_rdy = 1'b1;
        busy   = (wr_ptr != '0);
        if (in_vld && last_beat) state_d = S_EXP;
      end
      S_EXP:   if (exp_done) state_d = S_DIV;
      S_DIV:   if (div_done) state_d = S_OUT;
      S_OUT:   if (out_fire && out_last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    beat_max = max_q;
    for (int i = 0; i < LANES; i++) begin
      if (in_act[i] && ($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]) > beat_max))
        beat_max = $signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Piecewise-linear 2^d: mantissa (1+F) aligned to Q1.15, then shifted by the integer part.
  always_comb begin
    e_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      d_l[i]    = DW1'($signed(mem[rd_idx][i][DATA_WIDTH-1:0])) - DW1'(max_q);
      sh_l[i]   = -(d_l[i] >>> FRAC_BITS);
      e_lane[i] = (16'({1'b1, d_l[i][FRAC_BITS-1:0]}) << (15 - FRAC_BITS)) >> $unsigned(sh_l[i]);
      if (!rd_act[i] || ($unsigned(sh_l[i]) > DW1'(16))) e_lane[i] = '0;
      e_sum = e_sum + SW'(e_lane[i]);
    end
  end

  always_comb begin
    rem_sh = {rem_q, (div_cnt == 5'd0)};
    ge     = (rem_sh >= {1'b0, sum_q});
    recip  = (sum_q == '0) ? 16'h0000 : q_q;
  end

  always_comb begin
    out_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (17'((32'(mem[rd_idx][i][15:0]) * 32'(recip)) >> 15) > 17'h08000)
        out_lanes[i*16 +: 16] = 16'h8000;
      else
        out_lanes[i*16 +: 16] = 16'((32'(mem[rd_idx][i][15:0]) * 32'(recip)) >> 15);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++)
        mem[wr_idx][i] <= EW'($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]));
    end else if (state_q == S_EXP) begin
      for (int i = 0; i < LANES; i++)
        mem[rd_idx][i] <= EW'(e_lane[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      max_q    <= MAX_INIT;
      sum_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      div_cnt  <= '0;
      info_q   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      err_len  <= 1'b0;
    end else begin
      err_len <= accept && !in_last && (wr_ptr == PW'(MAX_BEATS - 1));
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            max_q  <= beat_max;
            rd_ptr <= '0;
            if (wr_ptr == '0) info_q <= in_info;
          end
        end
        S_EXP: begin
          sum_q  <= sum_q + e_sum;
          rd_ptr <= rd_ptr + PW'(1);
          if (exp_done) begin
            rem_q   <= '0;
            q_q     <= '0;
            div_cnt <= '0;
          end
        end
        S_DIV: begin
          rem_q   <= SW'(ge ? rem_sh - {1'b0, sum_q} : rem_sh);
          q_q     <= {q_q[14:0], ge};
          div_cnt <= div_cnt + 5'd1;
          if (div_done) rd_ptr <= '0;
        end
        S_OUT: begin
          if (!out_vld || (out_fire && !out_last)) begin
            out_vld  <= 1'b1;
            out_data <= out_lanes;
            out_last <= (rd_ptr == wr_ptr - PW'(1));
            rd_ptr   <= rd_ptr + PW'(1);
          end else if (out_fire) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            max_q    <= MAX_INIT;
            sum_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row_engine.sv
// Directed bench for softmax_row_engine: arithmetic row model plus per-cycle output scoreboard.
`timescale 1ns/1ps
module tb_softmax_row_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [19:0] in_info = '0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [63:0] out_data;
  logic        out_last;
  logic [19:0] out_info;
  logic        busy;
  logic        err_len;

  softmax_row_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last), .in_info(in_info),
`ifdef SOFTMAX_LANE_MASK_EN
    .in_mask(4'b0000),
`endif
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .out_info(out_info), .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          ntotal = 0;
  int          nbad = 0;
  logic [84:0] exp_q[$];
  logic [63:0] row_q[$];
  int          exp_total = 0;
  int          n_out = 0;
  int          n_err = 0;
  int          acc_cyc = 0;
  int          first_in_cyc = 0;
  int          out_rise_cyc = 0;
  logic        prev_vld = 1'b0;
  logic [63:0] last_out_data = '0;
  logic [19:0] last_out_info = '0;
  bit          stall_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    ntotal++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Row model: max, exp2 approximation (1+f/256)*2^-k, reciprocal 2^30/sum, saturating product.
  task automatic model_row(input logic [19:0] info);
    int mx, s, d, k, f, n;
    longint sum, r, o;
    longint e[$];
    logic [63:0] w, od;
    mx = -32768;
    sum = 0;
    n = row_q.size();
    for (int b = 0; b < n; b++) begin
      w = row_q[b];
      for (int l = 0; l < 4; l++) begin
        s = $signed(w[l*16 +: 16]);
        if (s > mx) mx = s;
      end
    end
    for (int b = 0; b < n; b++) begin
      w = row_q[b];
      for (int l = 0; l < 4; l++) begin
        s = $signed(w[l*16 +: 16]);
        d = s - mx;
        k = (-d + 255) / 256;
        f = d + 256 * k;
        e.push_back((k > 16) ? 0 : (((256 + f) * 128) >> k));
        sum += e[e.size()-1];
      end
    end
    r = (longint'(1) << 30) / sum;
    for (int b = 0; b < n; b++) begin
      od = '0;
      for (int l = 0; l < 4; l++) begin
        o = (e[b*4+l] * r) >> 15;
        if (o > 32768) o = 32768;
        od[l*16 +: 16] = 16'(o);
      end
      exp_q.push_back({od, (b == n - 1), info});
    end
    exp_total += n;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [19:0] info);
    int n = 0;
    in_vld = 1'b1; in_data = d; in_last = last; in_info = info;
    @(negedge clk);
    while (!in_rdy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      ntotal++; nbad++;
      $display("FAIL in_rdy_timeout: got 0 want 1");
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_row(input logic [19:0] info, input bit no_last);
    for (int b = 0; b < row_q.size(); b++) begin
      send_beat(row_q[b], !no_last && (b == row_q.size() - 1), info);
      if (b == 0) first_in_cyc = acc_cyc;
    end
  endtask

  task automatic wait_out();
    int n = 0;
    while (n_out < exp_total && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ntotal++;
    if (n_out < exp_total) begin
      nbad++;
      $display("FAIL out_timeout: got %0d beats want %0d", n_out, exp_total);
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard: every valid cycle must match the head of the expected queue; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_len) n_err++;
      if (out_vld) begin
        if (!prev_vld) out_rise_cyc = cyc;
        ntotal++;
        if (exp_q.size() == 0) begin
          nbad++;
          $display("FAIL unexpected_out: got data=%h last=%b info=%h want none", out_data, out_last, out_info);
        end else if ({out_data, out_last, out_info} !== exp_q[0]) begin
          nbad++;
          $display("FAIL out_beat: got data=%h last=%b info=%h want data=%h last=%b info=%h",
                   out_data, out_last, out_info, exp_q[0][84:21], exp_q[0][20], exp_q[0][19:0]);
        end
        ntotal++;
        if (in_rdy !== 1'b0) begin
          nbad++;
          $display("FAIL in_rdy_during_out: got %b want 0", in_rdy);
        end
        if (out_rdy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          last_out_data = out_data;
          last_out_info = out_info;
          n_out++;
        end
      end
    end
    prev_vld = rst_n && out_vld;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] w;
    logic [84:0] ex;
    int err_before;

    #12;
    check("rst_in_rdy",   64'(in_rdy),   64'd1);
    check("rst_out_vld",  64'(out_vld),  64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data,      64'd0);
    check("rst_out_info", 64'(out_info), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_err_len",  64'(err_len),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1 beat of zeros
    row_q = {};
    row_q.push_back(64'h0);
    model_row(20'h12345);
    ex = exp_q[exp_q.size()-1];
    check("model_zeros", ex[84:21], 64'h2000_2000_2000_2000);
    send_row(20'h12345, 1'b0);
    wait_out();
    check("t1_data", last_out_data, 64'h2000_2000_2000_2000);
    check("t1_info", 64'(last_out_info), 64'h12345);

    // 1 beat of descending integer scores
    row_q = {};
    row_q.push_back(64'hFD00_FE00_FF00_0000);
    model_row(20'h00ABC);
    ex = exp_q[exp_q.size()-1];
    check("model_desc", ex[84:21], 64'h0888_1111_2222_4444);
    send_row(20'h00ABC, 1'b0);
    wait_out();
    check("t2_data", last_out_data, 64'h0888_1111_2222_4444);

    // 2 beats of 1.0 each: latency and busy
    row_q = {};
    row_q.push_back(64'h0100_0100_0100_0100);
    row_q.push_back(64'h0100_0100_0100_0100);
    model_row(20'h00002);
    ex = exp_q[0];
    check("model_flat", ex[84:21], 64'h1000_1000_1000_1000);
    send_beat(row_q[0], 1'b0, 20'h00002);
    first_in_cyc = acc_cyc;
    check("busy_mid_load", 64'(busy), 64'd1);
    send_beat(row_q[1], 1'b1, 20'h00002);
    wait_out();
    check("t3_data", last_out_data, 64'h1000_1000_1000_1000);
    check("t3_latency", 64'(out_rise_cyc - first_in_cyc), 64'd36);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_in_rdy", 64'(in_rdy), 64'd1);

    // 4 beats with out_rdy stalls 1,0,0,1
    row_q = {};
    row_q.push_back(64'h0300_FD80_0050_FFF0);
    row_q.push_back(64'h02F0_0123_FE01_0001);
    row_q.push_back(64'h0000_0300_0100_FC00);
    row_q.push_back(64'h01AB_02CD_FF11_0299);
    model_row(20'hF00D4);
    stall_on = 1'b1;
    fork
      begin
        send_row(20'hF00D4, 1'b0);
        wait_out();
        stall_on = 1'b0;
      end
      begin
        int k = 0;
        while (stall_on && k < 3000) begin
          @(posedge clk); #1;
          out_rdy = (k % 4 == 0) || (k % 4 == 3);
          k++;
        end
        out_rdy = 1'b1;
      end
    join
    check("t4_info", 64'(last_out_info), 64'hF00D4);

    // MAX_BEATS beats without in_last, then a row held off until LOAD
    err_before = n_err;
    row_q = {};
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < 4; l++) w[l*16 +: 16] = 16'(-(b * 48 + l * 20));
      if (b == 0)  w[15:0]  = 16'h0040;
      if (b == 14) w[47:32] = 16'hF040;
      if (b == 14) w[63:48] = 16'hF140;
      if (b == 15) w[63:48] = 16'h8000;
      row_q.push_back(w);
    end
    model_row(20'h55555);
    send_row(20'h55555, 1'b1);
    row_q = {};
    row_q.push_back(64'h0);
    model_row(20'h00006);
    send_row(20'h00006, 1'b0);
    wait_out();
    check("err_len_pulses", 64'(n_err - err_before), 64'd1);
    check("t5b_data", last_out_data, 64'h2000_2000_2000_2000);

    // reset during EXP, then a fresh zero row
    row_q = {};
    row_q.push_back(64'h0100_0200_0300_0400);
    row_q.push_back(64'h0500_0600_0700_0800);
    row_q.push_back(64'h0000_0000_0000_0000);
    row_q.push_back(64'h0010_0020_0030_0040);
    send_row(20'h0BAD0, 1'b0);
    @(posedge clk); #1;
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_vld", 64'(out_vld), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    row_q = {};
    row_q.push_back(64'h0);
    model_row(20'h00007);
    send_row(20'h00007, 1'b0);
    wait_out();
    check("t6_data", last_out_data, 64'h2000_2000_2000_2000);
    check("t6_info", 64'(last_out_info), 64'h00007);
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
